// File: rtl/mul64_seq.sv
// mul64_seq: 64x64->128 unsigned shift-add multiplier sequencing one shared cla64 adder.
module cla64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        ci,
  output logic [63:0] s,
  output logic        co
);
  logic [63:0] g, p;
  logic [64:0] c;
  assign g = a & b;
  assign p = a ^ b;
  // 4-bit look-ahead groups, group carries rippled between groups
  always_comb begin
    c = '0;
    c[0] = ci;
    for (int k = 0; k < 64; k += 4) begin
      c[k+1] = g[k] | (p[k] & c[k]);
      c[k+2] = g[k+1] | (p[k+1] & g[k]) | (p[k+1] & p[k] & c[k]);
      c[k+3] = g[k+2] | (p[k+2] & g[k+1]) | (p[k+2] & p[k+1] & g[k]) | (p[k+2] & p[k+1] & p[k] & c[k]);
      c[k+4] = g[k+3] | (p[k+3] & g[k+2]) | (p[k+3] & p[k+2] & g[k+1]) | (p[k+3] & p[k+2] & p[k+1] & g[k])
             | (p[k+3] & p[k+2] & p[k+1] & p[k] & c[k]);
    end
  end
  assign s  = p ^ c[63:0];
  assign co = c[64];
endmodule

module mul64_seq (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         op_start,
  input  logic         op_clear,
  input  logic [63:0]  multiplicand,
  input  logic [63:0]  multiplier,
  output logic [127:0] result,
  output logic         busy,
  output logic         op_done
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t       state;
  logic [5:0]   cnt;
  logic [63:0]  m;
  logic [127:0] p;
  logic [63:0]  s;
  logic         co;
  cla64 u_cla (.a(p[127:64]), .b(p[0] ? m : 64'b0), .ci(1'b0), .s(s), .co(co));
  // The adder carry-out lands in bit 127; the 129th product bit is always zero so it is not stored
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      m     <= '0;
      p     <= '0;
    end else if (op_clear) begin
      state <= IDLE;
      cnt   <= '0;
      m     <= '0;
      p     <= '0;
    end else if (state != EXEC) begin
      if (op_start) begin
        m     <= multiplicand;
        p     <= {64'b0, multiplier};
        cnt   <= '0;
        state <= EXEC;
      end
    end else begin
      p   <= {co, s, p[63:1]};
      cnt <= cnt + 6'd1;
      if (cnt == 6'd63) state <= DONE;
    end
  assign result  = p;
  assign busy    = state == EXEC;
  assign op_done = state == DONE;
endmodule

// File: tb/tb_mul64_seq.sv
// tb_mul64_seq: directed vectors checked against a cycle-counting behavioural product model.
module tb_mul64_seq;
  logic         clk = 0;
  logic         reset_n = 0;
  logic         op_start = 0;
  logic         op_clear = 0;
  logic [63:0]  multiplicand = '0;
  logic [63:0]  multiplier = '0;
  logic [127:0] result;
  logic         busy;
  logic         op_done;
  int checks = 0;
  int errors = 0;
  int ms = 0;
  int left = 0;
  logic [127:0] mprod = '0;

  mul64_seq dut (
    .clk(clk), .reset_n(reset_n), .op_start(op_start), .op_clear(op_clear),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .result(result), .busy(busy), .op_done(op_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // model: 0=idle 1=exec 2=done; product is plain multiplication available after 64 edges
  always @(posedge clk or negedge reset_n)
    if (!reset_n) ms = 0;
    else if (op_clear) ms = 0;
    else if (ms != 1 && op_start) begin
      ms = 1;
      left = 64;
      mprod = {64'b0, multiplicand} * {64'b0, multiplier};
    end else if (ms == 1) begin
      left--;
      if (left == 0) ms = 2;
    end

  always @(negedge clk) begin
    chk("busy", {127'b0, busy}, {127'b0, ms == 1});
    chk("op_done", {127'b0, op_done}, {127'b0, ms == 2});
    if (ms == 0) chk("idle_result", result, '0);
    if (ms == 2) chk("done_result", result, mprod);
  end

  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic [127:0] exp, input string name);
    int n;
    @(posedge clk); #2;
    multiplicand = a; multiplier = b; op_start = 1;
    @(posedge clk); #2;
    op_start = 0;
    chk({name, "_busy_after_start"}, {127'b0, busy}, 128'd1);
    chk({name, "_done_drop"}, {127'b0, op_done}, 128'd0);
    n = 0;
    while (!op_done && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    chk({name, "_latency"}, 128'(n), 128'd64);
    chk({name, "_result"}, result, exp);
    chk({name, "_model"}, mprod, exp);
  endtask

  task automatic wait_edges(input int k);
    repeat (k) begin
      @(posedge clk); #2;
    end
  endtask

  initial begin
    #1;
    chk("reset_result", result, '0);
    chk("reset_busy", {127'b0, busy}, '0);
    chk("reset_done", {127'b0, op_done}, '0);
    #16 reset_n = 1;
    do_op(64'd3, 64'd5, 128'd15, "basic");
    wait_edges(3);
    chk("basic_hold", result, 128'd15);
    @(posedge clk); #2 op_clear = 1;
    @(posedge clk); #2 op_clear = 0;
    chk("clear_done", {127'b0, op_done}, '0);
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, "max");
    do_op(64'd0, 64'h1234_5678_9ABC_DEF0, 128'd0, "zero");
    do_op(64'd1, 64'hDEAD_BEEF_0000_0001, 128'h0000_0000_0000_0000_DEAD_BEEF_0000_0001, "identity");
    do_op(64'hDEAD_BEEF_0000_0001, 64'd1, 128'h0000_0000_0000_0000_DEAD_BEEF_0000_0001, "identity_swap");
    // abort: ignored start at iteration 10, clear at iteration 20
    @(posedge clk); #2 op_clear = 1;
    @(posedge clk); #2 op_clear = 0;
    multiplicand = 64'd7; multiplier = 64'd9; op_start = 1;
    @(posedge clk); #2 op_start = 0;
    wait_edges(10);
    multiplicand = 64'd100; multiplier = 64'd100; op_start = 1;
    @(posedge clk); #2 op_start = 0;
    chk("ignored_start_busy", {127'b0, busy}, 128'd1);
    wait_edges(9);
    op_clear = 1; op_start = 1;
    @(posedge clk); #2 op_clear = 0; op_start = 0;
    chk("abort_busy", {127'b0, busy}, '0);
    chk("abort_done", {127'b0, op_done}, '0);
    chk("abort_result", result, '0);
    do_op(64'd7, 64'd9, 128'd63, "after_abort");
    // restart straight from DONE
    @(posedge clk); #2 op_clear = 1;
    @(posedge clk); #2 op_clear = 0;
    do_op(64'd3, 64'd5, 128'd15, "pre_restart");
    do_op(64'h1_0000_0000, 64'h1_0000_0000, 128'h1_0000_0000_0000_0000, "restart");
    // async reset mid-EXEC
    @(posedge clk); #2 op_clear = 1;
    @(posedge clk); #2 op_clear = 0;
    multiplicand = 64'd3; multiplier = 64'd5; op_start = 1;
    @(posedge clk); #2 op_start = 0;
    wait_edges(30);
    #1 reset_n = 0;
    #1;
    chk("async_result", result, '0);
    chk("async_busy", {127'b0, busy}, '0);
    chk("async_done", {127'b0, op_done}, '0);
    wait_edges(2);
    #1 reset_n = 1;
    wait_edges(1);
    chk("post_reset_idle", {126'b0, busy, op_done}, '0);
    do_op(64'd3, 64'd5, 128'd15, "after_reset");
    wait_edges(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
